alu_rs_pool: RTL and testbench

ALU_RS_POOL -- requirements
Module: alu_rs_pool

---
 rtl/alu_rs_pkg.sv | 33 +++
 rtl/rs_age_select.sv | 64 ++++++
 rtl/alu_rs_pool.sv | 164 ++++++++++++++++
 tb/tb_alu_rs_pool.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_rs_pkg.sv
// Shared definitions for the ALU reservation-station pool: opcodes, the ready tag
// and the ROB age helper.
package alu_rs_pkg;

  typedef enum logic [5:0] {
    OP_ADDU = 6'b000000,
    OP_AND  = 6'b000001,
    OP_OR   = 6'b000010,
    OP_XOR  = 6'b000011,
    OP_SUBU = 6'b000100,
    OP_SLT  = 6'b010100,
    OP_SLTU = 6'b011100,
    OP_SLL  = 6'b100000,
    OP_SRL  = 6'b100010,
    OP_SRA  = 6'b100011
  } alu_op_e;

  localparam int unsigned TAG_READY = 0;

  typedef enum logic {
    LOCK_IDLE,
    LOCK_HELD
  } lock_state_e;

  // Distance of a tag from the commit pointer, modulo the tag space; smaller is older.
  function automatic int unsigned rs_age(input int unsigned tag, input int unsigned head,
                                         input int unsigned tag_w);
    int unsigned mask;
    mask = (tag_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << tag_w) - 32'd1);
    return (tag - head) & mask;
  endfunction

endpackage

// File: rtl/rs_age_select.sv
// Oldest-ready selection with a dispatch lock that keeps a stalled choice stable
// until it is accepted or squashed.
module rs_age_select
  import alu_rs_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAG_W = 5,
  localparam int unsigned IW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DEPTH-1:0]       ready,
  input  logic [DEPTH-1:0]       kill,
  input  logic [DEPTH*TAG_W-1:0] rob_tags,
  input  logic [TAG_W-1:0]       rob_head,
  input  logic                   disp_ready,
  output logic                   disp_valid,
  output logic                   disp_fire,
  output logic [IW-1:0]          sel_idx
);

  lock_state_e state, state_n;
  logic [IW-1:0] lock_idx, lock_idx_n, best_idx;
  logic          any_ready;
  int unsigned   best_age, cur_age;

  always_comb begin
    any_ready = 1'b0;
    best_idx  = '0;
    best_age  = 32'hFFFF_FFFF;
    cur_age   = 0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      cur_age = rs_age(32'(rob_tags[i*TAG_W +: TAG_W]), 32'(rob_head), TAG_W);
      if (ready[i] && (!any_ready || cur_age < best_age)) begin
        any_ready = 1'b1;
        best_idx  = IW'(i);
        best_age  = cur_age;
      end
    end
  end

  always_comb begin
    state_n    = state;
    lock_idx_n = lock_idx;
    sel_idx    = (state == LOCK_HELD) ? lock_idx : best_idx;
    disp_valid = (state == LOCK_HELD) | any_ready;
    disp_fire  = disp_valid & disp_ready;
    if (disp_fire) begin
      state_n = LOCK_IDLE;
    end else if (state == LOCK_HELD) begin
      if (kill[lock_idx]) state_n = LOCK_IDLE;
    end else if (disp_valid && !kill[best_idx]) begin
      state_n    = LOCK_HELD;
      lock_idx_n = best_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= LOCK_IDLE;
    else     state <= state_n;
    lock_idx <= lock_idx_n;
  end

endmodule

// File: rtl/alu_rs_pool.sv
// Age-ordered ALU reservation-station pool with CDB wakeup, issue bypass and
// ROB-tag based flush.
module alu_rs_pool
  import alu_rs_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = 32,
  parameter int unsigned TAG_W = 5,
  parameter int unsigned OP_W  = 6,
  parameter int unsigned NCDB  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic [DW-1:0]              issue_vj,
  input  logic [DW-1:0]              issue_vk,
  input  logic [TAG_W-1:0]           issue_qj,
  input  logic [TAG_W-1:0]           issue_qk,
  input  logic [OP_W-1:0]            issue_op,
  input  logic [TAG_W-1:0]           issue_rob,
  input  logic [NCDB-1:0]            cdb_valid,
  input  logic [NCDB*TAG_W-1:0]      cdb_tag,
  input  logic [NCDB*DW-1:0]         cdb_data,
  input  logic [TAG_W-1:0]           rob_head,
  input  logic                       flush,
  input  logic [TAG_W-1:0]           flush_tag,
  output logic                       disp_valid,
  input  logic                       disp_ready,
  output logic [DW-1:0]              disp_a,
  output logic [DW-1:0]              disp_b,
  output logic [OP_W-1:0]            disp_op,
  output logic [TAG_W-1:0]           disp_rob,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [TAG_W-1:0] RDY = TAG_W'(TAG_READY);

  logic [DEPTH-1:0] valid, valid_n, ready, kill;
  logic [TAG_W-1:0] qj [DEPTH], qk [DEPTH], rob [DEPTH];
  logic [TAG_W-1:0] qj_n [DEPTH], qk_n [DEPTH], rob_n [DEPTH];
  logic [DW-1:0]    vj [DEPTH], vk [DEPTH], vj_n [DEPTH], vk_n [DEPTH];
  logic [OP_W-1:0]  op [DEPTH], op_n [DEPTH];
  logic [DEPTH*TAG_W-1:0] rob_flat;
  logic [IW-1:0]    free_idx, sel_idx;
  logic [TAG_W-1:0] in_qj, in_qk;
  logic [DW-1:0]    in_vj, in_vk;
  logic             disp_fire, issue_young, accept;
  int unsigned      flush_age;

  always_comb begin
    count    = '0;
    free_idx = '0;
    rob_flat = '0;
    for (int unsigned i = DEPTH; i > 0; i--) begin
      if (!valid[i-1]) free_idx = IW'(i-1);
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      count = count + CW'(valid[i]);
      ready[i] = valid[i] && (qj[i] == RDY) && (qk[i] == RDY);
      rob_flat[i*TAG_W +: TAG_W] = rob[i];
    end
    full        = (count == CW'(DEPTH));
    empty       = (count == '0);
    issue_ready = ~full;
  end

  // Issue-time bypass; descending scan lets the lowest matching port win.
  always_comb begin
    in_qj = issue_qj;
    in_vj = issue_vj;
    in_qk = issue_qk;
    in_vk = issue_vk;
    for (int unsigned p = NCDB; p > 0; p--) begin
      if (cdb_valid[p-1] && issue_qj != RDY && cdb_tag[(p-1)*TAG_W +: TAG_W] == issue_qj) begin
        in_qj = RDY;
        in_vj = cdb_data[(p-1)*DW +: DW];
      end
      if (cdb_valid[p-1] && issue_qk != RDY && cdb_tag[(p-1)*TAG_W +: TAG_W] == issue_qk) begin
        in_qk = RDY;
        in_vk = cdb_data[(p-1)*DW +: DW];
      end
    end
  end

  always_comb begin
    valid_n     = valid;
    qj_n        = qj;
    qk_n        = qk;
    vj_n        = vj;
    vk_n        = vk;
    op_n        = op;
    rob_n       = rob;
    kill        = '0;
    flush_age   = rs_age(32'(flush_tag), 32'(rob_head), TAG_W);
    issue_young = flush && (rs_age(32'(issue_rob), 32'(rob_head), TAG_W) > flush_age);
    accept      = issue_valid && issue_ready && !issue_young;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      for (int unsigned p = NCDB; p > 0; p--) begin
        if (valid[i] && cdb_valid[p-1] && qj[i] != RDY && cdb_tag[(p-1)*TAG_W +: TAG_W] == qj[i]) begin
          qj_n[i] = RDY;
          vj_n[i] = cdb_data[(p-1)*DW +: DW];
        end
        if (valid[i] && cdb_valid[p-1] && qk[i] != RDY && cdb_tag[(p-1)*TAG_W +: TAG_W] == qk[i]) begin
          qk_n[i] = RDY;
          vk_n[i] = cdb_data[(p-1)*DW +: DW];
        end
      end
      if (flush && valid[i] && rs_age(32'(rob[i]), 32'(rob_head), TAG_W) > flush_age) begin
        kill[i]    = 1'b1;
        valid_n[i] = 1'b0;
      end
    end
    if (disp_fire) valid_n[sel_idx] = 1'b0;
    if (accept) begin
      valid_n[free_idx] = 1'b1;
      qj_n[free_idx]    = in_qj;
      qk_n[free_idx]    = in_qk;
      vj_n[free_idx]    = in_vj;
      vk_n[free_idx]    = in_vk;
      op_n[free_idx]    = issue_op;
      rob_n[free_idx]   = issue_rob;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) valid <= '0;
    else     valid <= valid_n;
  end

  always_ff @(posedge clk) begin
    qj  <= qj_n;
    qk  <= qk_n;
    vj  <= vj_n;
    vk  <= vk_n;
    op  <= op_n;
    rob <= rob_n;
  end

  rs_age_select #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_sel (
    .clk        (clk),
    .rst        (rst),
    .ready      (ready),
    .kill       (kill),
    .rob_tags   (rob_flat),
    .rob_head   (rob_head),
    .disp_ready (disp_ready),
    .disp_valid (disp_valid),
    .disp_fire  (disp_fire),
    .sel_idx    (sel_idx)
  );

  always_comb begin
    disp_a   = vj[sel_idx];
    disp_b   = vk[sel_idx];
    disp_op  = op[sel_idx];
    disp_rob = rob[sel_idx];
  end

endmodule

// File: tb/tb_alu_rs_pool.sv
// Directed bench for alu_rs_pool; expected dispatches are queued in the order they
// must leave the pool and checked at each handshake.
module tb_alu_rs_pool;
  import alu_rs_pkg::*;

  logic        clk = 1'b0;
  logic        rst, issue_valid, issue_ready, flush, disp_valid, disp_ready, full, empty;
  logic [31:0] issue_vj, issue_vk, disp_a, disp_b;
  logic [4:0]  issue_qj, issue_qk, issue_rob, rob_head, flush_tag, disp_rob;
  logic [5:0]  issue_op, disp_op;
  logic [1:0]  cdb_valid;
  logic [9:0]  cdb_tag;
  logic [63:0] cdb_data;
  logic [3:0]  count;

  typedef struct packed {
    logic [4:0]  rob;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  op;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  alu_rs_pool #(.DEPTH(8), .DW(32), .TAG_W(5), .OP_W(6), .NCDB(2)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_qj(issue_qj), .issue_qk(issue_qk),
    .issue_op(issue_op), .issue_rob(issue_rob), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .rob_head(rob_head), .flush(flush), .flush_tag(flush_tag),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_a(disp_a), .disp_b(disp_b),
    .disp_op(disp_op), .disp_rob(disp_rob), .count(count), .full(full), .empty(empty)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_issue(input logic [4:0] r, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] j, input logic [4:0] k, input logic [5:0] o);
    issue_rob = r; issue_vj = a; issue_vk = b; issue_qj = j; issue_qk = k; issue_op = o;
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic push(input logic [4:0] r, input logic [31:0] a, input logic [31:0] b,
                      input logic [5:0] o);
    exp_t e;
    e.rob = r; e.a = a; e.b = b; e.op = o;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    disp_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (empty) break;
      tick();
    end
    chk("drain_empty", empty, 1);
    disp_ready = 1'b0;
  endtask

  task automatic bcast(input logic [4:0] t, input logic [31:0] d);
    cdb_valid = 2'b01; cdb_tag = {5'd0, t}; cdb_data = {32'd0, d};
    tick();
    cdb_valid = 2'b00;
  endtask

  // Scoreboard: every handshake must match the next expected dispatch.
  always @(negedge clk) begin
    if (!rst && disp_valid && disp_ready) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL sb_underflow observed=rob%0d expected=none", disp_rob);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("disp_rob", disp_rob, mon_e.rob);
        chk("disp_a", disp_a, mon_e.a);
        chk("disp_b", disp_b, mon_e.b);
        chk("disp_op", disp_op, mon_e.op);
      end
    end
  end

  initial begin
    rst = 1'b1; issue_valid = 1'b0; issue_vj = '0; issue_vk = '0; issue_qj = '0; issue_qk = '0;
    issue_op = '0; issue_rob = '0; cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
    rob_head = 5'd1; flush = 1'b0; flush_tag = '0; disp_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_disp_valid", disp_valid, 0);

    // Fill to capacity while dispatch is stalled.
    for (int r = 1; r <= 8; r++) begin
      do_issue(5'(r), 32'(r * 16), 32'(r + 100), 5'd0, 5'd0, OP_ADDU);
      push(5'(r), 32'(r * 16), 32'(r + 100), OP_ADDU);
    end
    chk("full_full", full, 1);
    chk("full_issue_ready", issue_ready, 0);
    chk("full_count", count, 8);
    chk("full_disp_rob", disp_rob, 1);
    do_issue(5'd9, 32'h99, 32'h99, 5'd0, 5'd0, OP_AND);
    tick();
    chk("full_drop_count", count, 8);
    chk("stall_disp_rob", disp_rob, 1);
    chk("stall_disp_a", disp_a, 16);
    drain();

    // Issue and dispatch in the same cycle.
    do_issue(5'd10, 32'h10, 32'h20, 5'd0, 5'd0, OP_OR);
    push(5'd10, 32'h10, 32'h20, OP_OR);
    push(5'd11, 32'h11, 32'h21, OP_SLT);
    disp_ready = 1'b1;
    do_issue(5'd11, 32'h11, 32'h21, 5'd0, 5'd0, OP_SLT);
    disp_ready = 1'b0;
    chk("swap_count", count, 1);
    chk("swap_disp_rob", disp_rob, 11);
    drain();

    // Two ports match the same tag: port 0 wins.
    do_issue(5'd3, 32'h0, 32'h7, 5'd5, 5'd0, OP_SUBU);
    push(5'd3, 32'hAAAA0000, 32'h7, OP_SUBU);
    chk("wake_pre_valid", disp_valid, 0);
    cdb_valid = 2'b11; cdb_tag = {5'd5, 5'd5}; cdb_data = {32'h1234, 32'hAAAA0000};
    tick();
    cdb_valid = 2'b00;
    chk("wake_valid", disp_valid, 1);
    chk("wake_a", disp_a, 32'hAAAA0000);
    drain();

    // Issue bypass on port 1; port 0 carries tag 0 which must never match.
    cdb_valid = 2'b11; cdb_tag = {5'd7, 5'd0}; cdb_data = {32'h42, 32'hDEAD};
    do_issue(5'd4, 32'h9, 32'h0, 5'd0, 5'd7, OP_XOR);
    cdb_valid = 2'b00;
    push(5'd4, 32'h9, 32'h42, OP_XOR);
    chk("byp_valid", disp_valid, 1);
    chk("byp_b", disp_b, 32'h42);
    chk("byp_a", disp_a, 32'h9);
    drain();

    // Wrap-around age: head 30, entries woken together.
    rob_head = 5'd30;
    do_issue(5'd3, 32'h0, 32'd3, 5'd25, 5'd0, OP_SLL);
    do_issue(5'd1, 32'h0, 32'd1, 5'd25, 5'd0, OP_SLL);
    do_issue(5'd31, 32'h0, 32'd31, 5'd25, 5'd0, OP_SLL);
    push(5'd31, 32'h5A5A, 32'd31, OP_SLL);
    push(5'd1, 32'h5A5A, 32'd1, OP_SLL);
    push(5'd3, 32'h5A5A, 32'd3, OP_SLL);
    chk("wrap_pre_valid", disp_valid, 0);
    bcast(5'd25, 32'h5A5A);
    chk("wrap_first", disp_rob, 31);
    drain();

    // Flush younger than rob 4, with a younger issue in the same cycle.
    rob_head = 5'd1;
    do_issue(5'd2, 32'h0, 32'd2, 5'd20, 5'd0, OP_SRA);
    do_issue(5'd4, 32'h0, 32'd4, 5'd20, 5'd0, OP_SRA);
    do_issue(5'd6, 32'h0, 32'd6, 5'd20, 5'd0, OP_SRA);
    flush = 1'b1; flush_tag = 5'd4;
    do_issue(5'd7, 32'h0, 32'd7, 5'd20, 5'd0, OP_SRA);
    flush = 1'b0;
    chk("flush_count", count, 2);
    push(5'd2, 32'h77, 32'd2, OP_SRA);
    push(5'd4, 32'h77, 32'd4, OP_SRA);
    bcast(5'd20, 32'h77);
    drain();

    // Reset mid-stream with a locked dispatch and a competing issue.
    for (int r = 1; r <= 5; r++) do_issue(5'(r), 32'(r), 32'(r), 5'd0, 5'd0, OP_SRL);
    tick();
    chk("pre_rst_count", count, 5);
    chk("pre_rst_valid", disp_valid, 1);
    rst = 1'b1; disp_ready = 1'b1;
    cdb_valid = 2'b01; cdb_tag = {5'd0, 5'd3}; cdb_data = '0;
    issue_rob = 5'd6; issue_qj = 5'd0; issue_qk = 5'd0; issue_valid = 1'b1;
    tick();
    rst = 1'b0; disp_ready = 1'b0; cdb_valid = 2'b00; issue_valid = 1'b0;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_valid", disp_valid, 0);
    chk("mid_rst_issue_ready", issue_ready, 1);

    chk("sb_leftover", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
